// File: rtl/ahb_pkg.sv
// AHB-Lite transfer, burst and response codes plus the burst beat-count helper
// shared by the two-master arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  localparam int unsigned BEAT_CNT_W = 4;
  typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

  // Remaining beats after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic beat_cnt_t burst_beats(input logic [2:0] hburst);
    beat_cnt_t beats;
    beats = '0;
    case (hburst)
      HBURST_INCR4,  HBURST_WRAP4:  beats = beat_cnt_t'(3);
      HBURST_INCR8,  HBURST_WRAP8:  beats = beat_cnt_t'(7);
      HBURST_INCR16, HBURST_WRAP16: beats = beat_cnt_t'(15);
      default:                      beats = '0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// One AHB-Lite link: used for each master port and for the shared bus.
interface ahb_master_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic [3:0]            HPROT;
  logic                  HWRITE;
  logic                  HMASTLOCK;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HTRANS, HBURST, HSIZE, HPROT, HWRITE, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HBURST, HSIZE, HPROT, HWRITE, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_burst_tracker.sv
// Beat counter and burst/lock hold for the current address-phase owner;
// arb_ok marks a cycle where the grant may move.
module ahb_burst_tracker
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hready,
  input  logic       hresp,
  input  logic       dp_valid,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hmastlock,
  output logic       arb_ok
);

  beat_cnt_t beat_cnt;

  // An error response aborts the burst, so the remaining beats are forgotten.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (dp_valid && hresp) begin
      beat_cnt <= '0;
    end else if (hready) begin
      if (htrans == HTRANS_NONSEQ) begin
        beat_cnt <= burst_beats(hburst);
      end else if (htrans == HTRANS_SEQ && beat_cnt != '0) begin
        beat_cnt <= beat_cnt - beat_cnt_t'(1);
      end
    end
  end

  assign arb_ok = hready && !hmastlock && (beat_cnt == '0) &&
                  !(htrans == HTRANS_SEQ || htrans == HTRANS_BUSY);

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter and bus mux (m0 = CPU, m1 = DMA).
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of m0 priority.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb_master_arbiter_if.slave  m0,
  ahb_master_arbiter_if.slave  m1,
  ahb_master_arbiter_if.master bus,
  output logic                cpu_grant,
  output logic                dma_grant
);

  owner_e addr_owner;
  owner_e owner_next;
  owner_e dp_owner;
  logic   dp_valid;
  logic   arb_ok;
  logic   req0;
  logic   req1;

  logic [ADDR_WIDTH-1:0] haddr_sel;
  logic [DATA_WIDTH-1:0] hwdata_sel;
  logic [1:0]            htrans_sel;
  logic [2:0]            hburst_sel;
  logic                  hmastlock_sel;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_grant;
`endif

  assign req0 = m0.HTRANS[1];
  assign req1 = m1.HTRANS[1];

  // Address-phase mux follows the owner with no added latency.
  always_comb begin
    haddr_sel     = m0.HADDR;
    htrans_sel    = m0.HTRANS;
    hburst_sel    = m0.HBURST;
    hmastlock_sel = m0.HMASTLOCK;
    bus.HSIZE     = m0.HSIZE;
    bus.HPROT     = m0.HPROT;
    bus.HWRITE    = m0.HWRITE;
    if (addr_owner == OWNER_DMA) begin
      haddr_sel     = m1.HADDR;
      htrans_sel    = m1.HTRANS;
      hburst_sel    = m1.HBURST;
      hmastlock_sel = m1.HMASTLOCK;
      bus.HSIZE     = m1.HSIZE;
      bus.HPROT     = m1.HPROT;
      bus.HWRITE    = m1.HWRITE;
    end
  end

  assign bus.HADDR     = haddr_sel;
  assign bus.HTRANS    = htrans_sel;
  assign bus.HBURST    = hburst_sel;
  assign bus.HMASTLOCK = hmastlock_sel;

  assign hwdata_sel = (dp_owner == OWNER_DMA) ? m1.HWDATA : m0.HWDATA;
  assign bus.HWDATA = hwdata_sel;

  ahb_burst_tracker u_burst_tracker (
    .clk      (HCLK),
    .rst      (HRESET),
    .hready   (bus.HREADY),
    .hresp    (bus.HRESP),
    .dp_valid (dp_valid),
    .htrans   (htrans_sel),
    .hburst   (hburst_sel),
    .hmastlock(hmastlock_sel),
    .arb_ok   (arb_ok)
  );

  // Next grant: park when nobody asks, resolve contention by priority or turn.
  always_comb begin
    owner_next = addr_owner;
    if (arb_ok) begin
      if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
        owner_next = (last_grant == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
`else
        owner_next = OWNER_CPU;
`endif
      end else if (req1) begin
        owner_next = OWNER_DMA;
      end else if (req0) begin
        owner_next = OWNER_CPU;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_owner <= OWNER_CPU;
      dp_valid   <= 1'b0;
      dp_owner   <= OWNER_CPU;
    end else begin
      addr_owner <= owner_next;
      if (bus.HREADY) begin
        dp_valid <= htrans_sel[1];
        dp_owner <= addr_owner;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_grant <= OWNER_CPU;
    end else if (owner_next != addr_owner) begin
      last_grant <= owner_next;
    end
  end
`endif

  // A master owning the data phase that has lost the address phase must wait
  // while it still requests, so its next address is not taken early.
  function automatic logic master_ready(input owner_e me, input logic req);
    logic rdy;
    if (dp_valid && dp_owner == me) begin
      rdy = bus.HREADY && (addr_owner == me || !req);
    end else if (addr_owner == me) begin
      rdy = bus.HREADY;
    end else begin
      rdy = !req;
    end
    return rdy;
  endfunction

  assign m0.HREADY = master_ready(OWNER_CPU, req0);
  assign m1.HREADY = master_ready(OWNER_DMA, req1);

  assign m0.HRESP = bus.HRESP && dp_valid && (dp_owner == OWNER_CPU);
  assign m1.HRESP = bus.HRESP && dp_valid && (dp_owner == OWNER_DMA);

  assign m0.HRDATA = bus.HRDATA;
  assign m1.HRDATA = bus.HRDATA;

  assign cpu_grant = (addr_owner == OWNER_CPU);
  assign dma_grant = (addr_owner == OWNER_DMA);

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed table-driven bench for ahb_master_arbiter (default fixed-priority build).
module tb_ahb_master_arbiter;

  localparam logic [31:0] M0_ADDR  = 32'h1000_0000;
  localparam logic [31:0] M1_ADDR  = 32'h2000_0000;
  localparam logic [31:0] M1_WDATA = 32'h5555_AAAA;

  logic HCLK;
  logic HRESET;
  logic cpu_grant;
  logic dma_grant;

  ahb_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  ahb_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
  ahb_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .m0       (m0_if),
    .m1       (m1_if),
    .bus      (bus_if),
    .cpu_grant(cpu_grant),
    .dma_grant(dma_grant)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0] t0;  logic [2:0] b0;  logic l0;
    logic [1:0] t1;  logic [2:0] b1;
    logic hr;        logic rs;
    logic cg;        logic [1:0] ht;
    logic r0;        logic r1;
    logic e0;        logic e1;
    logic hws;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input int t0, b0, l0, t1, b1, hr, rs,
                              cg, ht, r0, r1, e0, e1, hws);
    vec_t r;
    r.t0 = 2'(t0); r.b0 = 3'(b0); r.l0 = 1'(l0);
    r.t1 = 2'(t1); r.b1 = 3'(b1);
    r.hr = 1'(hr); r.rs = 1'(rs);
    r.cg = 1'(cg); r.ht = 2'(ht);
    r.r0 = 1'(r0); r.r1 = 1'(r1);
    r.e0 = 1'(e0); r.e1 = 1'(e1);
    r.hws = 1'(hws);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    m0_if.HTRANS = 2'd0; m0_if.HBURST = 3'd0; m0_if.HMASTLOCK = 1'b0;
    m1_if.HTRANS = 2'd0; m1_if.HBURST = 3'd0; m1_if.HMASTLOCK = 1'b0;
    bus_if.HREADY = 1'b1; bus_if.HRESP = 1'b0;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    m0_if.HADDR = M0_ADDR; m0_if.HSIZE = 3'd2; m0_if.HPROT = 4'h3; m0_if.HWRITE = 1'b1;
    m0_if.HWDATA = 32'h0;
    m1_if.HADDR = M1_ADDR; m1_if.HSIZE = 3'd2; m1_if.HPROT = 4'h1; m1_if.HWRITE = 1'b0;
    m1_if.HWDATA = M1_WDATA;
    bus_if.HRDATA = 32'h0;
    idle_all();

    // Rows: m0 trans/burst/lock, m1 trans/burst, HREADY, HRESP | cpu_grant,
    // bus HTRANS, m0/m1 HREADY, m0/m1 HRESP, HWDATA from m1.
    // DMA-only SINGLE read
    vecs.push_back(mk(0,0,0, 2,0, 1,0, 1,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 2,0, 1,0, 0,2,1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0, 1,0, 0,0,1,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0, 1,0, 0,0,1,1,0,0,1));
    // CPU INCR4 write, DMA requests from beat 2
    vecs.push_back(mk(2,3,0, 0,0, 1,0, 0,0,0,1,0,0,1));
    vecs.push_back(mk(2,3,0, 0,0, 1,0, 1,2,1,1,0,0,1));
    vecs.push_back(mk(3,3,0, 2,0, 1,0, 1,3,1,0,0,0,0));
    vecs.push_back(mk(3,3,0, 2,0, 1,0, 1,3,1,0,0,0,0));
    vecs.push_back(mk(3,3,0, 2,0, 1,0, 1,3,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 2,0, 1,0, 1,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 2,0, 1,0, 0,2,1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0, 1,0, 0,0,1,1,0,0,1));
    // Locked sequence of 3 SINGLEs with DMA waiting
    vecs.push_back(mk(2,0,1, 0,0, 1,0, 0,0,0,1,0,0,1));
    vecs.push_back(mk(2,0,1, 2,0, 1,0, 1,2,1,0,0,0,1));
    vecs.push_back(mk(2,0,1, 2,0, 1,0, 1,2,1,0,0,0,0));
    vecs.push_back(mk(2,0,1, 2,0, 1,0, 1,2,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 2,0, 1,0, 1,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 2,0, 1,0, 0,2,1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0, 1,0, 0,0,1,1,0,0,1));
    // Both masters requesting every cycle
    vecs.push_back(mk(2,0,0, 2,0, 1,0, 0,2,0,1,0,0,1));
    vecs.push_back(mk(2,0,0, 2,0, 1,0, 1,2,1,0,0,0,1));
    vecs.push_back(mk(2,0,0, 2,0, 1,0, 1,2,1,0,0,0,0));
    vecs.push_back(mk(2,0,0, 2,0, 1,0, 1,2,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0, 1,0, 1,0,1,1,0,0,0));
    // DMA INCR4 hit by wait states then a two-cycle error
    vecs.push_back(mk(0,0,0, 2,3, 1,0, 1,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 2,3, 1,0, 0,2,1,1,0,0,0));
    vecs.push_back(mk(2,0,0, 3,3, 0,0, 0,3,0,0,0,0,1));
    vecs.push_back(mk(2,0,0, 3,3, 0,0, 0,3,0,0,0,0,1));
    vecs.push_back(mk(2,0,0, 3,3, 0,1, 0,3,0,0,0,1,1));
    vecs.push_back(mk(2,0,0, 0,3, 1,1, 0,0,0,1,0,1,1));
    vecs.push_back(mk(2,0,0, 0,0, 1,0, 1,2,1,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0, 1,0, 1,0,1,1,0,0,0));

    // Reset with both masters idle
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    #1;
    check("rst cpu_grant", 32'(cpu_grant), 32'd1);
    check("rst dma_grant", 32'(dma_grant), 32'd0);
    check("rst HTRANS", 32'(bus_if.HTRANS), 32'd0);
    check("rst m0_HREADY", 32'(m0_if.HREADY), 32'd1);
    check("rst m1_HREADY", 32'(m1_if.HREADY), 32'd1);
    check("rst m0_HRESP", 32'(m0_if.HRESP), 32'd0);
    check("rst m1_HRESP", 32'(m1_if.HRESP), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic [31:0] m0_wd;
      logic [31:0] rd;
      v = vecs[i];
      m0_wd = 32'h0A00_0000 + 32'(i);
      rd    = 32'hDEAD_BEEF ^ 32'(i);
      tick();
      m0_if.HTRANS = v.t0; m0_if.HBURST = v.b0; m0_if.HMASTLOCK = v.l0;
      m0_if.HWDATA = m0_wd;
      m1_if.HTRANS = v.t1; m1_if.HBURST = v.b1;
      bus_if.HREADY = v.hr; bus_if.HRESP = v.rs; bus_if.HRDATA = rd;
      #1;
      check($sformatf("row%0d cpu_grant", i), 32'(cpu_grant), 32'(v.cg));
      check($sformatf("row%0d dma_grant", i), 32'(dma_grant), 32'(!v.cg));
      check($sformatf("row%0d HTRANS", i), 32'(bus_if.HTRANS), 32'(v.ht));
      check($sformatf("row%0d HADDR", i), bus_if.HADDR, v.cg ? M0_ADDR : M1_ADDR);
      check($sformatf("row%0d HBURST", i), 32'(bus_if.HBURST), 32'(v.cg ? v.b0 : v.b1));
      check($sformatf("row%0d HWRITE", i), 32'(bus_if.HWRITE), 32'(v.cg));
      check($sformatf("row%0d HMASTLOCK", i), 32'(bus_if.HMASTLOCK), 32'(v.cg & v.l0));
      check($sformatf("row%0d m0_HREADY", i), 32'(m0_if.HREADY), 32'(v.r0));
      check($sformatf("row%0d m1_HREADY", i), 32'(m1_if.HREADY), 32'(v.r1));
      check($sformatf("row%0d m0_HRESP", i), 32'(m0_if.HRESP), 32'(v.e0));
      check($sformatf("row%0d m1_HRESP", i), 32'(m1_if.HRESP), 32'(v.e1));
      check($sformatf("row%0d HWDATA", i), bus_if.HWDATA, v.hws ? M1_WDATA : m0_wd);
      check($sformatf("row%0d m0_HRDATA", i), m0_if.HRDATA, rd);
      check($sformatf("row%0d m1_HRDATA", i), m1_if.HRDATA, rd);
    end

    // Reset in the middle of a DMA INCR4 burst
    tick();
    idle_all();
    m1_if.HTRANS = 2'd2; m1_if.HBURST = 3'd3;
    #1;
    check("midrst req cpu_grant", 32'(cpu_grant), 32'd1);
    check("midrst req m1_HREADY", 32'(m1_if.HREADY), 32'd0);
    tick();
    #1;
    check("midrst nonseq dma_grant", 32'(dma_grant), 32'd1);
    check("midrst nonseq HTRANS", 32'(bus_if.HTRANS), 32'd2);
    tick();
    m1_if.HTRANS = 2'd3;
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    m1_if.HTRANS = 2'd0;
    bus_if.HRESP = 1'b1;
    #1;
    check("midrst cpu_grant", 32'(cpu_grant), 32'd1);
    check("midrst dma_grant", 32'(dma_grant), 32'd0);
    check("midrst HTRANS", 32'(bus_if.HTRANS), 32'd0);
    check("midrst m0_HRESP", 32'(m0_if.HRESP), 32'd0);
    check("midrst m1_HRESP", 32'(m1_if.HRESP), 32'd0);
    check("midrst m0_HREADY", 32'(m0_if.HREADY), 32'd1);
    check("midrst m1_HREADY", 32'(m1_if.HREADY), 32'd1);
    tick();
    bus_if.HRESP = 1'b0;
    m1_if.HTRANS = 2'd2; m1_if.HBURST = 3'd0;
    #1;
    check("postrst req cpu_grant", 32'(cpu_grant), 32'd1);
    check("postrst req m1_HREADY", 32'(m1_if.HREADY), 32'd0);
    tick();
    #1;
    check("postrst dma_grant", 32'(dma_grant), 32'd1);
    check("postrst HADDR", bus_if.HADDR, M1_ADDR);
    check("postrst m1_HREADY", 32'(m1_if.HREADY), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
